// File: rtl/icache_pkg.sv
// Shared geometry, FSM encoding and address-slice helpers
// for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int OFFSET_W = 2;
    localparam int INDEX_W  = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES    = 1 << INDEX_W;
    localparam int WORDS    = 1 << OFFSET_W;

    localparam logic [DATA_W-1:0] NOP = '0;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(
        input logic [ADDR_W-1:0] a
    );
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(
        input logic [ADDR_W-1:0] a
    );
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(
        input logic [ADDR_W-1:0] a
    );
        return a[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid bits, tag array and data array for the instruction cache.
// One write port for refill beats, one asynchronous read port for lookup.
module icache_line_store
    import icache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                clear_all,
    input  logic                inval,
    input  logic [INDEX_W-1:0]  inval_index,
    input  logic                fill,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES*WORDS];

    // Reset and flush win over any per-line update in the same cycle
    always_ff @(posedge clock) begin
        if (reset || clear_all) begin
            valid <= '0;
        end else begin
            if (inval)
                valid[inval_index] <= 1'b0;
            if (fill)
                valid[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (fill)
            tags[fill_index] <= fill_tag;
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            data[{wr_index, wr_offset}] <= wr_data;
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_offset}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache serving the IF stage, with
// line refill from backing memory and saturating hit/miss counters.
module inst_cache
    import icache_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] i_datain,
    output logic              i_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    state_t state;
    state_t state_next;

    logic [TAG_W-1:0]    line_tag;
    logic [INDEX_W-1:0]  line_index;
    logic [OFFSET_W-1:0] word_cnt;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;

    logic hit;
    logic start;
    logic beat;
    logic done;

    assign hit = rd_valid
              && (rd_tag == addr_tag(pc))
              && (state == IDLE);

    assign i_stall  = fetch_en && !hit;
    assign i_datain = (fetch_en && hit) ? rd_data : NOP;
    assign mem_req  = (state == REFILL);
    assign mem_addr = {line_tag, line_index, word_cnt};

    always_comb begin
        state_next = state;
        start      = 1'b0;
        beat       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && fetch_en && !hit) begin
                    start      = 1'b1;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                // A beat arriving together with flush is dropped
                if (flush) begin
                    state_next = IDLE;
                end else if (mem_valid) begin
                    beat = 1'b1;
                    if (word_cnt == OFFSET_W'(WORDS - 1)) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            line_tag   <= '0;
            line_index <= '0;
            word_cnt   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                line_tag   <= addr_tag(pc);
                line_index <= addr_index(pc);
                word_cnt   <= '0;
            end else if (flush) begin
                word_cnt <= '0;
            end else if (beat) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (start && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
            if (fetch_en && hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
        end
    end

    icache_line_store u_store (
        .clock       (clock),
        .reset       (reset),
        .clear_all   (flush),
        .inval       (start),
        .inval_index (addr_index(pc)),
        .fill        (done),
        .fill_index  (line_index),
        .fill_tag    (line_tag),
        .wr_en       (beat),
        .wr_index    (line_index),
        .wr_offset   (word_cnt),
        .wr_data     (mem_rdata),
        .rd_index    (addr_index(pc)),
        .rd_offset   (addr_offset(pc)),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data)
    );

endmodule
